// File: rtl/dac_multichannel_sequencer.sv
// Multichannel DAC waveform sequencer: per-channel sawtooth/triangle accumulators,
// one 24-bit command per channel per sample tick via the SPI DAC Send/Ready handshake.
module dac_multichannel_sequencer #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PERIOD     = 100,
    parameter logic [3:0]  CMD_NIBBLE = 4'h3
) (
    input  logic                           Clock_48MHz,
    input  logic                           Reset,
    input  logic                           i_Enable,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_Step,
    input  logic [CHANNELS-1:0]            i_Mode,
    input  logic                           i_DAC_Ready,
    output logic                           o_DAC_Send,
    output logic [23:0]                    o_DAC_Data,
    output logic                           o_Frame_Done,
    output logic                           o_Overrun,
    output logic                           o_Busy
);

    localparam int unsigned CW  = $clog2(PERIOD);
    localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = '1;

    typedef enum logic [1:0] {StIdle, StIssue, StAck} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q;
    logic                  tick;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [DATA_WIDTH-1:0] acc_q [CHANNELS];
    logic [CHANNELS-1:0]   dir_q;
    logic                  send_q, send_d;
    logic                  done_q, done_d;
    logic                  overrun_q;
    logic [23:0]           data_q;

    logic [DATA_WIDTH-1:0] acc_sel, step_sel, acc_next;
    logic [DATA_WIDTH:0]   sum;
    logic                  dir_next;
    logic [15:0]           aligned;

    assign tick = (count_q == CW'(PERIOD - 1));

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        send_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick && i_Enable) begin
                    state_d = StIssue;
                    ch_d    = '0;
                end
            end
            StIssue: begin
                if (i_DAC_Ready) begin
                    state_d = StAck;
                    send_d  = 1'b1;
                end
            end
            StAck: begin
                // Ready is ignored here so the driver has one cycle to drop it.
                if (ch_q == CHW'(CHANNELS - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_sel  = acc_q[ch_q];
        step_sel = i_Step[ch_q*DATA_WIDTH +: DATA_WIDTH];
        sum      = {1'b0, acc_sel} + {1'b0, step_sel};
        acc_next = sum[DATA_WIDTH-1:0];
        dir_next = dir_q[ch_q];
        aligned  = 16'(acc_sel) << (16 - DATA_WIDTH);
        if (i_Mode[ch_q]) begin
            if (!dir_q[ch_q]) begin
                if (sum > {1'b0, MAX_VAL}) begin
                    acc_next = MAX_VAL;
                    dir_next = 1'b1;
                end
            end else if (step_sel > acc_sel) begin
                acc_next = '0;
                dir_next = 1'b0;
            end else begin
                acc_next = acc_sel - step_sel;
            end
        end
    end

    always_ff @(posedge Clock_48MHz) begin
        if (Reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            ch_q      <= '0;
            send_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            dir_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            count_q <= tick ? '0 : count_q + 1'b1;
            state_q <= state_d;
            ch_q    <= ch_d;
            send_q  <= send_d;
            done_q  <= done_d;
            if (send_d) begin
                data_q <= {CMD_NIBBLE, 4'(ch_q), aligned};
            end
            // The accumulator advances in the Send cycle, after its old value was latched.
            if (state_q == StAck) begin
                acc_q[ch_q] <= acc_next;
                dir_q[ch_q] <= dir_next;
            end
            if (tick && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign o_DAC_Send   = send_q;
    assign o_DAC_Data   = data_q;
    assign o_Frame_Done = done_q;
    assign o_Overrun    = overrun_q;
    assign o_Busy       = (state_q != StIdle);

endmodule
